// File: rtl/simd_alu_arbiter_pkg.sv
// Shared SIMD constants, opcode encodings and the per-lane ALU operation.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package simd_alu_arbiter_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 32;
    localparam int DATA_W = LANES * LANE_W;
    localparam int OP_W   = 4;

    typedef enum logic [OP_W-1:0] {
        OP_PASS    = 4'd0,
        OP_ADD     = 4'd1,
        OP_SUB     = 4'd2,
        OP_AND     = 4'd3,
        OP_OR      = 4'd4,
        OP_XOR     = 4'd5,
        OP_SHL     = 4'd6,
        OP_ABSDIFF = 4'd7
    } alu_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              zero;
        logic              id;
    } resp_t;

    // Encodings 8..15 are reserved and produce zero.
    function automatic logic [LANE_W-1:0] lane_op(input logic [OP_W-1:0]   op,
                                                  input logic [LANE_W-1:0] x,
                                                  input logic [LANE_W-1:0] y);
        logic [LANE_W-1:0] r;
        r = '0;
        case (alu_op_e'(op))
            OP_PASS:    r = x;
            OP_ADD:     r = x + y;
            OP_SUB:     r = x - y;
            OP_AND:     r = x & y;
            OP_OR:      r = x | y;
            OP_XOR:     r = x ^ y;
            OP_SHL:     r = x << y[4:0];
            OP_ABSDIFF: r = (x > y) ? (x - y) : (y - x);
            default:    r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/simd_alu_arbiter_alu.sv
// Four-lane 32-bit SIMD ALU with an all-lanes-zero flag.
// Latency: combinational.
// Backpressure: none; output follows inputs.
module alu
    import simd_alu_arbiter_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero_flag
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign result[i*LANE_W +: LANE_W] = lane_op(op, a[i*LANE_W +: LANE_W], b[i*LANE_W +: LANE_W]);
    end

    assign zero_flag = (result == '0);

endmodule

// File: rtl/simd_alu_arbiter.sv
// Two-requester round-robin front end sharing one SIMD ALU, registered result.
// Latency: 1 cycle from accepted command to resp_valid.
// Backpressure: both readies drop while a held result is not being consumed.
module simd_alu_arbiter
    import simd_alu_arbiter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_zero,
    output logic              resp_id,
    output logic [CNT_W-1:0]  op_count
);

    logic              last_grant;
    logic              can_accept;
    logic              pick1;
    logic              accept;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    resp_t             resp_q;

    assign can_accept = !resp_valid || resp_ready;

    // last_grant=1 means requester 1 won last; on contention the other side wins.
    assign pick1      = req1_valid && (!req0_valid || !last_grant);
    assign accept     = !rst && can_accept && (req0_valid || req1_valid);
    assign req0_ready = accept && !pick1;
    assign req1_ready = accept && pick1;

    assign alu_op = pick1 ? req1_op : req0_op;
    assign alu_a  = pick1 ? req1_a  : req0_a;
    assign alu_b  = pick1 ? req1_b  : req0_b;

    alu u_alu (
        .op        (alu_op),
        .a         (alu_a),
        .b         (alu_b),
        .result    (alu_result),
        .zero_flag (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_q     <= '0;
            op_count   <= '0;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                resp_valid <= 1'b1;
                resp_q     <= '{data: alu_result, zero: alu_zero, id: pick1};
                last_grant <= pick1;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
            if (resp_valid && resp_ready) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

    assign resp_data = resp_q.data;
    assign resp_zero = resp_q.zero;
    assign resp_id   = resp_q.id;

endmodule

// File: tb/tb_simd_alu_arbiter.sv
// Randomized bench for simd_alu_arbiter against a cycle-level reference model.
module tb_simd_alu_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [3:0]   req0_op, req1_op;
    logic [127:0] req0_a, req0_b, req1_a, req1_b;
    logic         resp_valid, resp_ready;
    logic [127:0] resp_data;
    logic         resp_zero, resp_id;
    logic [3:0]   op_count;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic         m_valid, m_zero, m_id, m_last;
    logic [127:0] m_data;
    logic [3:0]   m_count;
    logic         exp_r0, exp_r1, obs_r0, obs_r1;

    simd_alu_arbiter #(.CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_zero  (resp_zero),
        .resp_id    (resp_id),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] alu_ref(input logic [3:0] op, input logic [127:0] a, input logic [127:0] b);
        logic [127:0] r;
        logic [31:0]  x, y, z;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            x = a[i*32 +: 32];
            y = b[i*32 +: 32];
            case (op)
                4'd0: z = x;
                4'd1: z = x + y;
                4'd2: z = x - y;
                4'd3: z = x & y;
                4'd4: z = x | y;
                4'd5: z = x ^ y;
                4'd6: z = x << (y % 32);
                4'd7: z = (x > y) ? x - y : y - x;
                default: z = 32'd0;
            endcase
            r[i*32 +: 32] = z;
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic randomize_cmds();
        req0_op = 4'($urandom_range(0, 15));
        req1_op = 4'($urandom_range(0, 15));
        req0_a  = rand128();
        req0_b  = ($urandom_range(0, 3) == 0) ? req0_a : rand128();
        req1_a  = rand128();
        req1_b  = ($urandom_range(0, 3) == 0) ? req1_a : rand128();
    endtask

    // One clock: drive at negedge, observe readies, advance model at posedge.
    task automatic step(input logic v0, input logic v1, input logic rr);
        logic can, win;
        @(negedge clk);
        req0_valid = v0;
        req1_valid = v1;
        resp_ready = rr;
        #1;
        obs_r0 = req0_ready;
        obs_r1 = req1_ready;
        can    = !m_valid || rr;
        win    = (v0 && v1) ? !m_last : v1;
        exp_r0 = !rst && can && (v0 || v1) && !win;
        exp_r1 = !rst && can && (v0 || v1) && win;
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_zero = 1'b0; m_id = 1'b0;
            m_count = 4'd0; m_last = 1'b1;
        end else begin
            if (m_valid && rr) m_count = m_count + 4'd1;
            if (exp_r0 || exp_r1) begin
                m_data  = win ? alu_ref(req1_op, req1_a, req1_b) : alu_ref(req0_op, req0_a, req0_b);
                m_zero  = (m_data == '0);
                m_id    = win;
                m_last  = win;
                m_valid = 1'b1;
            end else if (rr) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        randomize_cmds();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b1);
            n_checks++;
            if ({obs_r0, obs_r1} !== 2'b00) begin
                n_errors++;
                $display("FAIL reset_ready: got %b required 00", {obs_r0, obs_r1});
            end
        end
        n_checks++;
        if ({resp_valid, resp_zero, resp_id, op_count, resp_data} !== {3'b000, 4'd0, 128'd0}) begin
            n_errors++;
            $display("FAIL reset_state: valid=%b zero=%b id=%b cnt=%0d data=%h required all zero",
                     resp_valid, resp_zero, resp_id, op_count, resp_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        req0_op = 4'b0101;
        req0_a  = 128'h8;
        req0_b  = 128'h8;
        step(1'b1, 1'b0, 1'b1);
        n_checks++;
        if ({obs_r0, obs_r1} !== 2'b10) begin
            n_errors++;
            $display("FAIL single_ready: got %b required 10", {obs_r0, obs_r1});
        end
        n_checks++;
        if ({resp_valid, resp_id, resp_zero, resp_data} !== {1'b1, 1'b0, m_zero, m_data} || resp_zero !== 1'b1) begin
            n_errors++;
            $display("FAIL single_resp: valid=%b id=%b zero=%b data=%h required 1 0 %b %h",
                     resp_valid, resp_id, resp_zero, resp_data, m_zero, m_data);
        end
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (op_count !== 4'd1 || resp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_count: cnt=%0d valid=%b required 1 0", op_count, resp_valid);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            randomize_cmds();
            step(1'b1, 1'b1, 1'b1);
            n_checks++;
            if ({obs_r0, obs_r1} !== {i[0] == 1'b0, i[0] == 1'b1} || {obs_r0, obs_r1} !== {exp_r0, exp_r1}) begin
                n_errors++;
                $display("FAIL contention_grant[%0d]: got %b required %b", i, {obs_r0, obs_r1}, {exp_r0, exp_r1});
            end
            n_checks++;
            if ({resp_valid, resp_id, resp_zero, resp_data} !== {1'b1, i[0], m_zero, m_data}) begin
                n_errors++;
                $display("FAIL contention_resp[%0d]: valid=%b id=%b zero=%b data=%h required 1 %b %b %h",
                         i, resp_valid, resp_id, resp_zero, resp_data, i[0], m_zero, m_data);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [130:0] held;
        step(1'b0, 1'b0, 1'b1);
        randomize_cmds();
        step(1'b1, 1'b1, 1'b0);
        held = {resp_valid, resp_id, resp_zero, resp_data};
        for (int i = 0; i < 3; i++) begin
            randomize_cmds();
            step(1'b1, 1'b1, 1'b0);
            n_checks++;
            if ({obs_r0, obs_r1} !== 2'b00 || {resp_valid, resp_id, resp_zero, resp_data} !== held
                || held !== {m_valid, m_id, m_zero, m_data}) begin
                n_errors++;
                $display("FAIL backpressure_hold[%0d]: rdy=%b out=%h required rdy=00 out=%h",
                         i, {obs_r0, obs_r1}, {resp_valid, resp_id, resp_zero, resp_data}, held);
            end
        end
        randomize_cmds();
        step(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (resp_id !== !held[129] || {resp_valid, resp_zero, resp_data} !== {1'b1, m_zero, m_data}) begin
            n_errors++;
            $display("FAIL backpressure_release: id=%b data=%h required %b %h", resp_id, resp_data, !held[129], m_data);
        end
    endtask

    task automatic test_zero_flag();
        step(1'b0, 1'b0, 1'b1);
        req1_op = 4'b0111;
        req1_a  = {32'd1, 32'd3, 32'd7, 32'd15};
        req1_b  = req1_a;
        step(1'b0, 1'b1, 1'b1);
        n_checks++;
        if ({resp_valid, resp_id, resp_zero, resp_data} !== {1'b1, 1'b1, m_zero, m_data}) begin
            n_errors++;
            $display("FAIL zero_flag: valid=%b id=%b zero=%b data=%h required 1 1 %b %h",
                     resp_valid, resp_id, resp_zero, resp_data, m_zero, m_data);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 300; i++) begin
            randomize_cmds();
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            n_checks++;
            if ({obs_r0, obs_r1, resp_valid, resp_id, resp_zero, op_count, resp_data}
                !== {exp_r0, exp_r1, m_valid, m_id, m_zero, m_count, m_data}) begin
                n_errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random[%0d]: rdy=%b v=%b id=%b z=%b cnt=%0d data=%h required rdy=%b v=%b id=%b z=%b cnt=%0d data=%h",
                             i, {obs_r0, obs_r1}, resp_valid, resp_id, resp_zero, op_count, resp_data,
                             {exp_r0, exp_r1}, m_valid, m_id, m_zero, m_count, m_data);
            end
        end
    endtask

    task automatic test_reset_midflight();
        step(1'b0, 1'b0, 1'b1);
        randomize_cmds();
        step(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        n_checks++;
        if ({obs_r0, obs_r1, resp_valid, op_count} !== {3'b000, 4'd0}) begin
            n_errors++;
            $display("FAIL midflight_reset: rdy=%b valid=%b cnt=%0d required 00 0 0", {obs_r0, obs_r1}, resp_valid, op_count);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1);
            n_checks++;
            if (resp_valid !== 1'b0 || op_count !== 4'd0) begin
                n_errors++;
                $display("FAIL midflight_stale[%0d]: valid=%b cnt=%0d required 0 0", i, resp_valid, op_count);
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            randomize_cmds();
            step(1'b1, 1'b0, 1'b1);
        end
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (op_count !== 4'd1 || op_count !== m_count) begin
            n_errors++;
            $display("FAIL counter_wrap: cnt=%0d required 1", op_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        req0_op = '0; req1_op = '0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        m_valid = 1'b0; m_data = '0; m_zero = 1'b0; m_id = 1'b0; m_count = 4'd0; m_last = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_zero_flag();
        test_random();
        test_reset_midflight();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
